// File: rtl/adder_pipe.sv
// adder_pipe: pipelined segmented-carry adder/subtractor, one SEG_W slice per stage.
// Ports: i_clk, i_rst_n, i_valid/o_ready (in), i_A, i_B, i_cin, i_sub, o_valid/i_ready (out), o_S, o_cout
// Optional: define ADDER_PIPE_OVF_EN to add o_ovf (signed overflow of the result).
module adder_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_S,
  output logic             o_cout
`ifdef ADDER_PIPE_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int NSEG = (SEG_W < 1) ? 1 : WIDTH / SEG_W;

  if (SEG_W < 1) begin : g_bad_seg
    $error("adder_pipe: SEG_W must be >= 1");
  end else if ((WIDTH % SEG_W) != 0) begin : g_bad_width
    $error("adder_pipe: WIDTH must be a multiple of SEG_W");
  end

  // Stall-all: every stage moves only when the output slot frees up.
  logic adv;
  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv;

  // Subtraction is A + ~B + 1; carry-in is ignored in that mode.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  assign b_eff   = i_sub ? ~i_B : i_B;
  assign cin_eff = i_sub | i_cin;

  for (genvar j = 0; j < NSEG; j++) begin : g_stg
    // AW: operand bits still to be summed; RW: result bits known after this stage.
    localparam int AW = WIDTH - j * SEG_W;
    localparam int RW = (j + 1) * SEG_W;

    logic [AW-1:0]    a_in;
    logic [AW-1:0]    b_in;
    logic             c_in;
    logic             v_in;
    logic [SEG_W:0]   seg;
    logic [RW-1:0]    s_nx;
    logic [RW-1:0]    s_q;
    logic             c_q;
    logic             v_q;

    if (j == 0) begin : g_head
      assign a_in = i_A;
      assign b_in = b_eff;
      assign c_in = cin_eff;
      assign v_in = i_valid;
    end else begin : g_body
      assign a_in = g_stg[j-1].g_fwd.a_q;
      assign b_in = g_stg[j-1].g_fwd.b_q;
      assign c_in = g_stg[j-1].c_q;
      assign v_in = g_stg[j-1].v_q;
    end

    assign seg = {1'b0, a_in[SEG_W-1:0]}
               + {1'b0, b_in[SEG_W-1:0]}
               + {{SEG_W{1'b0}}, c_in};

    // Lower result slices ride along with the newly summed slice on top.
    if (j == 0) begin : g_s0
      assign s_nx = seg[SEG_W-1:0];
    end else begin : g_sn
      assign s_nx = {seg[SEG_W-1:0], g_stg[j-1].s_q};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= seg[SEG_W];
        s_q <= s_nx;
      end
    end

    // Upper operand slices not yet summed, forwarded to later stages.
    if (j < NSEG - 1) begin : g_fwd
      logic [AW-SEG_W-1:0] a_q;
      logic [AW-SEG_W-1:0] b_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[AW-1:SEG_W];
          b_q <= b_in[AW-1:SEG_W];
        end
      end
    end

`ifdef ADDER_PIPE_OVF_EN
    // Carry into the MSB is recovered as a^b^sum at that bit.
    if (j == NSEG - 1) begin : g_ovf
      logic ovf_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= a_in[SEG_W-1] ^ b_in[SEG_W-1]
                 ^ seg[SEG_W-1] ^ seg[SEG_W];
        end
      end
    end
`endif
  end

  assign o_valid = g_stg[NSEG-1].v_q;
  assign o_S     = g_stg[NSEG-1].s_q;
  assign o_cout  = g_stg[NSEG-1].c_q;
`ifdef ADDER_PIPE_OVF_EN
  assign o_ovf   = g_stg[NSEG-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: vector table, random streams with backpressure, and mid-flight reset.
// Reference model is whole-word arithmetic on the operands.
module tb_adder_pipe;

  localparam int W    = 32;
  localparam int SW   = 8;
  localparam int NSEG = W / SW;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  i_A;
  logic [W-1:0]  i_B;
  logic          i_cin;
  logic          i_sub;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_S;
  logic          o_cout;
`ifdef ADDER_PIPE_OVF_EN
  logic          o_ovf;
`endif

  adder_pipe #(.WIDTH(W), .SEG_W(SW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_A     (i_A),
    .i_B     (i_B),
    .i_cin   (i_cin),
    .i_sub   (i_sub),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_S     (o_S),
    .o_cout  (o_cout)
`ifdef ADDER_PIPE_OVF_EN
    ,
    .o_ovf   (o_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Plain integer semantics: unsigned sum/difference, borrow, signed range.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    res_t r;
    longint ua, ub, sa, sb, us, ss;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      us = ua - ub;
      ss = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      us = ua + ub + longint'(cin);
      ss = sa + sb + longint'(cin);
      r.cout = (us >= 64'sd4294967296);
    end
    r.s   = us[W-1:0];
    r.ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    return r;
  endfunction

  task automatic send_one(input vec_t v, input string name);
    int lat;
    i_A = v.a; i_B = v.b; i_cin = v.cin; i_sub = v.sub;
    i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, 64'(lat), 64'(NSEG));
    chk({name, "_s"}, 64'(o_S), 64'(v.s));
    chk({name, "_cout"}, 64'(o_cout), 64'(v.cout));
`ifdef ADDER_PIPE_OVF_EN
    chk({name, "_ovf"}, 64'(o_ovf), 64'(v.ovf));
`endif
  endtask

  task automatic drain();
    i_valid = 1'b0; i_ready = 1'b1;
    repeat (NSEG + 1) begin @(posedge clk); #1; end
  endtask

  task automatic run_stream(input int nops, input int vpct, input int rpct,
                            input int max_cyc, input bit full);
    int sent, outs, cyc, first_out, last_out;
    bit stalled;
    logic [W-1:0] prev_s;
    logic prev_c;
    res_t e;
    sent = 0; outs = 0; cyc = 0;
    first_out = -1; last_out = -1;
    stalled = 1'b0; prev_s = '0; prev_c = 1'b0;
    while ((sent < nops || exp_q.size() != 0) && cyc < max_cyc) begin
      i_ready = ($urandom_range(99) < rpct);
      i_valid = (sent < nops) && ($urandom_range(99) < vpct);
      i_A   = $urandom;
      i_B   = $urandom;
      i_cin = $urandom_range(1);
      i_sub = $urandom_range(1);
      #1;
      chk("o_ready", 64'(o_ready), 64'(!(o_valid && !i_ready)));
      if (stalled) begin
        chk("hold_valid", 64'(o_valid), 64'(1));
        chk("hold_s", 64'(o_S), 64'(prev_s));
        chk("hold_cout", 64'(o_cout), 64'(prev_c));
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("stream_s", 64'(o_S), 64'(e.s));
          chk("stream_cout", 64'(o_cout), 64'(e.cout));
`ifdef ADDER_PIPE_OVF_EN
          chk("stream_ovf", 64'(o_ovf), 64'(e.ovf));
`endif
        end
        outs++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_A, i_B, i_cin, i_sub));
        sent++;
      end
      stalled = o_valid && !i_ready;
      prev_s = o_S;
      prev_c = o_cout;
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_timeout", 64'(cyc >= max_cyc), 64'(0));
    chk("stream_count", 64'(outs), 64'(nops));
    if (full) chk("stream_gapless", 64'(last_out - first_out + 1), 64'(nops));
    i_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[3] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    tbl[4] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[6] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
    tbl[7] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};

    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_A = '0; i_B = '0; i_cin = 1'b0; i_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_s", 64'(o_S), 64'(0));
    chk("rst_cout", 64'(o_cout), 64'(0));
    chk("rst_ready", 64'(o_ready), 64'(1));
`ifdef ADDER_PIPE_OVF_EN
    chk("rst_ovf", 64'(o_ovf), 64'(0));
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) begin
      send_one(tbl[k], $sformatf("vec%0d", k));
    end
    drain();

    run_stream(10, 100, 100, 60, 1'b1);
    run_stream(60, 70, 50, 800, 1'b0);

    // Three ops in flight, then a one-cycle asynchronous reset.
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_A = $urandom; i_B = $urandom;
      i_cin = 1'b0; i_sub = 1'b0; i_valid = 1'b1;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("flush_valid", 64'(o_valid), 64'(0));
    chk("flush_s", 64'(o_S), 64'(0));
    chk("flush_cout", 64'(o_cout), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < NSEG + 2; k++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", 64'(o_valid), 64'(0));
    end
    send_one(tbl[4], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
